// File: rtl/game_frame_scheduler.sv
`default_nettype none
// +------------------------------------------------------------------+
// | game_frame_scheduler                                             |
// | Menu/game/over sequencer: frame tick, erase/update/check/draw    |
// | handshakes, gravity flag, frame counter and overrun flag.        |
// | Revision 1.0                                                     |
// +------------------------------------------------------------------+
module game_frame_scheduler #(
  parameter int TICK_DIV = 833333,
  parameter int CW       = 20
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        i_go,
  input  logic        i_grav,
  input  logic        i_erase_done,
  input  logic        i_update_done,
  input  logic        i_check_done,
  input  logic        i_collide,
  input  logic        i_draw_done,
  output logic        o_erase_start,
  output logic        o_update_start,
  output logic        o_check_start,
  output logic        o_draw_start,
  output logic        o_startgame,
  output logic        o_grav_dir,
  output logic [15:0] o_frame_count,
  output logic        o_overrun
);

  typedef enum logic [2:0] {
    S_MENU      = 3'd0,
    S_MENU_WAIT = 3'd1,
    S_IDLE      = 3'd2,
    S_ERASE     = 3'd3,
    S_UPDATE    = 3'd4,
    S_CHECK     = 3'd5,
    S_DRAW      = 3'd6,
    S_OVER      = 3'd7
  } state_t;

  localparam logic [CW-1:0] c_TICK_LAST = CW'(TICK_DIV - 1);

  state_t        r_state;
  state_t        w_next;
  logic          r_first;
  logic          r_go_prev;
  logic          r_grav_prev;
  logic [CW-1:0] r_cnt;
  logic          r_tick_pending;
  logic          r_grav_req;
  logic          r_grav_dir;
  logic [15:0]   r_frame_count;
  logic          r_overrun;

  logic w_go_rise;
  logic w_grav_rise;
  logic w_in_game;
  logic w_tick;
  logic w_game_start;
  logic w_pending_clr;
  logic w_upd_first;
  logic w_draw_accept;

  assign w_go_rise     = i_go & ~r_go_prev;
  assign w_grav_rise   = i_grav & ~r_grav_prev;
  assign w_in_game     = (r_state == S_IDLE)   || (r_state == S_ERASE) ||
                         (r_state == S_UPDATE) || (r_state == S_CHECK) ||
                         (r_state == S_DRAW);
  assign w_tick        = w_in_game && (r_cnt == c_TICK_LAST);
  assign w_game_start  = (r_state == S_MENU_WAIT) && !i_go;
  assign w_pending_clr = (r_state == S_IDLE) && r_tick_pending;
  assign w_upd_first   = (r_state == S_UPDATE) && r_first;
  assign w_draw_accept = (r_state == S_DRAW) && !r_first && i_draw_done;

  // Done inputs are ignored in a phase's first cycle (r_first) so a stale
  // done from the previous frame cannot short-circuit the phase.
  always_comb begin
    w_next         = r_state;
    o_erase_start  = 1'b0;
    o_update_start = 1'b0;
    o_check_start  = 1'b0;
    o_draw_start   = 1'b0;
    o_startgame    = 1'b0;
    case (r_state)
      S_MENU: begin
        if (w_go_rise) w_next = S_MENU_WAIT;
      end
      S_MENU_WAIT: begin
        if (!i_go) w_next = S_IDLE;
      end
      S_IDLE: begin
        o_startgame = 1'b1;
        if (r_tick_pending) w_next = S_ERASE;
      end
      S_ERASE: begin
        o_startgame   = 1'b1;
        o_erase_start = r_first;
        if (!r_first && i_erase_done) w_next = S_UPDATE;
      end
      S_UPDATE: begin
        o_startgame    = 1'b1;
        o_update_start = r_first;
        if (!r_first && i_update_done) w_next = S_CHECK;
      end
      S_CHECK: begin
        o_startgame   = 1'b1;
        o_check_start = r_first;
        if (!r_first && i_check_done) w_next = i_collide ? S_OVER : S_DRAW;
      end
      S_DRAW: begin
        o_startgame  = 1'b1;
        o_draw_start = r_first;
        if (w_draw_accept) w_next = S_IDLE;
      end
      S_OVER: begin
        if (w_go_rise) w_next = S_MENU;
      end
      default: begin
        w_next = S_MENU;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state     <= S_MENU;
      r_first     <= 1'b0;
      r_go_prev   <= 1'b1;
      r_grav_prev <= 1'b1;
    end else begin
      r_state     <= w_next;
      r_first     <= (w_next != r_state);
      r_go_prev   <= i_go;
      r_grav_prev <= i_grav;
    end
  end

  // Frame tick divider and single-entry tick latch; a tick landing on a
  // still-pending latch is dropped and flagged.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_cnt          <= '0;
      r_tick_pending <= 1'b0;
      r_overrun      <= 1'b0;
    end else if (w_game_start) begin
      r_cnt          <= '0;
      r_tick_pending <= 1'b0;
      r_overrun      <= 1'b0;
    end else begin
      if (w_in_game) r_cnt <= w_tick ? '0 : r_cnt + CW'(1);
      if (w_tick) begin
        r_tick_pending <= 1'b1;
        if (r_tick_pending) r_overrun <= 1'b1;
      end else if (w_pending_clr) begin
        r_tick_pending <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_grav_req <= 1'b0;
      r_grav_dir <= 1'b0;
    end else if (w_game_start) begin
      r_grav_req <= 1'b0;
      r_grav_dir <= 1'b0;
    end else if (w_upd_first && r_grav_req) begin
      r_grav_dir <= ~r_grav_dir;
      r_grav_req <= w_grav_rise;
    end else if (w_grav_rise && w_in_game) begin
      r_grav_req <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_frame_count <= 16'd0;
    end else if (w_game_start) begin
      r_frame_count <= 16'd0;
    end else if (w_draw_accept) begin
      r_frame_count <= r_frame_count + 16'd1;
    end
  end

  assign o_grav_dir    = r_grav_dir;
  assign o_frame_count = r_frame_count;
  assign o_overrun     = r_overrun;

endmodule
`default_nettype wire
